// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Round-robin IFU/LSU arbiter onto one memory port, with timeout.
// Revision : 1.0
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_resp_valid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_resp_err,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [7:0]        lsu_wmask,
    output logic              lsu_resp_valid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_resp_err,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [7:0]        mem_wmask,
    input  logic              mem_resp_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_resp_err
);

    localparam int   CNT_W = $clog2(TIMEOUT + 1);
    localparam logic M_IFU = 1'b0;
    localparam logic M_LSU = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                r_owner;
    logic                r_last_grant;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_wen;
    logic [DATA_W-1:0]   r_wdata;
    logic [7:0]          r_wmask;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;

    logic                w_grant_lsu;
    logic                w_grant_ifu;
    logic                w_idle;
    logic                w_accept;
    logic                w_expire;
    logic                w_timeout_fire;
    logic                w_unused_wmask;

    assign w_unused_wmask = ^lsu_wmask[7:4];

    // Tie goes to whichever master did not win last time.
    assign w_grant_lsu = lsu_req_valid && (!ifu_req_valid || (r_last_grant == M_IFU));
    assign w_grant_ifu = ifu_req_valid && !w_grant_lsu;

    assign w_idle        = (r_state == S_IDLE) && !rst;
    assign ifu_req_ready = w_idle && w_grant_ifu;
    assign lsu_req_ready = w_idle && w_grant_lsu;
    assign w_accept      = ifu_req_ready || lsu_req_ready;

    // >= also catches a request handshake that lands exactly on the expiry cycle.
    assign w_expire       = (r_cnt >= CNT_W'(TIMEOUT - 1));
    assign w_timeout_fire = w_expire &&
                            (((r_state == S_REQ)  && !mem_req_ready) ||
                             ((r_state == S_WAIT) && !mem_resp_valid));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_next = S_REQ;
            S_REQ: begin
                if (mem_req_ready)       w_next = S_WAIT;
                else if (w_timeout_fire) w_next = S_RESP;
            end
            S_WAIT: begin
                if (mem_resp_valid)      w_next = S_RESP;
                else if (w_timeout_fire) w_next = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_owner      <= M_IFU;
            r_last_grant <= M_LSU;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_wen        <= 1'b0;
            r_wdata      <= '0;
            r_wmask      <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_owner      <= w_grant_lsu;
                r_last_grant <= w_grant_lsu;
                r_cnt        <= '0;
                r_addr       <= w_grant_lsu ? lsu_addr : ifu_addr;
                r_wen        <= w_grant_lsu && lsu_wen;
                r_wdata      <= w_grant_lsu ? lsu_wdata : '0;
                r_wmask      <= w_grant_lsu ? {4'h0, lsu_wmask[3:0]} : 8'h00;
            end else if ((r_state == S_REQ) || (r_state == S_WAIT)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // A real response beats an expiring counter in the same cycle.
            if ((r_state == S_WAIT) && mem_resp_valid) begin
                r_rdata <= r_wen ? '0 : mem_rdata;
                r_err   <= mem_resp_err;
            end else if (w_timeout_fire) begin
                r_rdata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    assign mem_req_valid = (r_state == S_REQ);
    assign mem_wen       = r_wen;
    assign mem_addr      = r_addr;
    assign mem_wdata     = r_wdata;
    assign mem_wmask     = r_wmask;

    assign ifu_resp_valid = (r_state == S_RESP) && (r_owner == M_IFU);
    assign lsu_resp_valid = (r_state == S_RESP) && (r_owner == M_LSU);
    assign ifu_rdata      = ifu_resp_valid ? r_rdata : '0;
    assign lsu_rdata      = lsu_resp_valid ? r_rdata : '0;
    assign ifu_resp_err   = ifu_resp_valid && r_err;
    assign lsu_resp_err   = lsu_resp_valid && r_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Purpose  : Directed + randomized transaction-level check of mem_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;
    localparam int NEVER   = 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic              ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [ADDR_W-1:0] ifu_addr;
    logic [DATA_W-1:0] ifu_rdata;
    logic              lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
    logic [ADDR_W-1:0] lsu_addr;
    logic [DATA_W-1:0] lsu_wdata, lsu_rdata;
    logic [7:0]        lsu_wmask;
    logic              mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [7:0]        mem_wmask;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) u_dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata), .mem_resp_err(mem_resp_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: which master won the previous arbitration (reset value: LSU).
    bit exp_last_lsu;

    logic [ADDR_W-1:0] t_ifu_addr, t_lsu_addr;
    logic              t_lsu_wen, t_mem_err;
    logic [DATA_W-1:0] t_lsu_wdata, t_mem_rdata;
    logic [7:0]        t_lsu_wmask;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        ifu_req_valid  = 1'b0; ifu_addr  = '0;
        lsu_req_valid  = 1'b0; lsu_wen   = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wmask = '0;
        mem_req_ready  = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0; mem_resp_err = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".ifu_req_ready"},  ifu_req_ready,  0);
        chk({tag, ".lsu_req_ready"},  lsu_req_ready,  0);
        chk({tag, ".ifu_resp_valid"}, ifu_resp_valid, 0);
        chk({tag, ".lsu_resp_valid"}, lsu_resp_valid, 0);
        chk({tag, ".ifu_rdata"},      ifu_rdata,      0);
        chk({tag, ".lsu_rdata"},      lsu_rdata,      0);
        chk({tag, ".ifu_resp_err"},   ifu_resp_err,   0);
        chk({tag, ".lsu_resp_err"},   lsu_resp_err,   0);
        chk({tag, ".mem_req_valid"},  mem_req_valid,  0);
        chk({tag, ".mem_wen"},        mem_wen,        0);
        chk({tag, ".mem_addr"},       mem_addr,       0);
        chk({tag, ".mem_wdata"},      mem_wdata,      0);
        chk({tag, ".mem_wmask"},      mem_wmask,      0);
    endtask

    // A memory response while nothing is outstanding must go nowhere.
    task automatic idle_stray();
        idle_inputs();
        mem_resp_valid = 1'b1; mem_rdata = $urandom(); mem_resp_err = 1'($urandom());
        @(negedge clk);
        chk("stray.ifu_resp_valid", ifu_resp_valid, 0);
        chk("stray.lsu_resp_valid", lsu_resp_valid, 0);
        chk("stray.mem_req_valid",  mem_req_valid,  0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("stray_after.ifu_resp_valid", ifu_resp_valid, 0);
        chk("stray_after.lsu_resp_valid", lsu_resp_valid, 0);
        chk("stray_after.mem_req_valid",  mem_req_valid,  0);
        @(posedge clk); #1;
    endtask

    // One transaction, entered in an IDLE cycle just after a rising edge.
    // rd: cycles mem_req_ready is held low; dr: cycles from mem accept to mem response.
    task automatic run_txn(input bit iv, input bit lv, input int rd, input int dr, input bit noise);
        bit                own_lsu, tmo, in_req, mine_i, mine_l;
        int                r, p;
        logic [ADDR_W-1:0] e_addr;
        logic              e_wen, e_err;
        logic [DATA_W-1:0] e_wdata, e_rdata;
        logic [7:0]        e_wmask;

        if (iv && lv) own_lsu = !exp_last_lsu;
        else          own_lsu = lv;

        ifu_req_valid = iv; ifu_addr = t_ifu_addr;
        lsu_req_valid = lv; lsu_addr = t_lsu_addr; lsu_wen = t_lsu_wen;
        lsu_wdata = t_lsu_wdata; lsu_wmask = t_lsu_wmask;
        mem_req_ready = 1'b0;
        mem_resp_valid = noise && 1'($urandom()); mem_rdata = $urandom(); mem_resp_err = 1'($urandom());
        @(negedge clk);
        chk("grant.ifu_req_ready", ifu_req_ready, iv && !own_lsu);
        chk("grant.lsu_req_ready", lsu_req_ready, own_lsu);
        @(posedge clk); #1;
        exp_last_lsu = own_lsu;

        e_addr  = own_lsu ? t_lsu_addr : t_ifu_addr;
        e_wen   = own_lsu && t_lsu_wen;
        e_wdata = own_lsu ? t_lsu_wdata : '0;
        e_wmask = own_lsu ? {4'h0, t_lsu_wmask[3:0]} : 8'h00;
        r   = 1 + rd + dr;
        tmo = (r > TIMEOUT);
        p   = tmo ? TIMEOUT + 1 : r + 1;
        e_rdata = (tmo || e_wen) ? '0 : t_mem_rdata;
        e_err   = tmo ? 1'b1 : t_mem_err;

        for (int c = 1; c <= p; c++) begin
            ifu_req_valid = noise && 1'($urandom()); ifu_addr = $urandom();
            lsu_req_valid = noise && 1'($urandom()); lsu_addr = $urandom();
            lsu_wen = 1'($urandom()); lsu_wdata = $urandom(); lsu_wmask = 8'($urandom());
            mem_req_ready = (c == 1 + rd);
            if (c == r) begin
                mem_resp_valid = 1'b1; mem_rdata = t_mem_rdata; mem_resp_err = t_mem_err;
            end else begin
                mem_resp_valid = noise && (c <= 1 + rd || c == p) && 1'($urandom());
                mem_rdata = $urandom(); mem_resp_err = 1'($urandom());
            end
            @(negedge clk);
            in_req = (c <= 1 + rd) && (c <= TIMEOUT);
            mine_i = (c == p) && !own_lsu;
            mine_l = (c == p) && own_lsu;
            chk("mem_req_valid", mem_req_valid, in_req);
            if (in_req) begin
                chk("mem_addr",  mem_addr,  e_addr);
                chk("mem_wen",   mem_wen,   e_wen);
                chk("mem_wdata", mem_wdata, e_wdata);
                chk("mem_wmask", mem_wmask, e_wmask);
            end
            chk("busy.ifu_req_ready", ifu_req_ready, 0);
            chk("busy.lsu_req_ready", lsu_req_ready, 0);
            chk("ifu_resp_valid", ifu_resp_valid, mine_i);
            chk("lsu_resp_valid", lsu_resp_valid, mine_l);
            chk("ifu_rdata",      ifu_rdata,      mine_i ? e_rdata : '0);
            chk("lsu_rdata",      lsu_rdata,      mine_l ? e_rdata : '0);
            chk("ifu_resp_err",   ifu_resp_err,   mine_i && e_err);
            chk("lsu_resp_err",   lsu_resp_err,   mine_l && e_err);
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic rand_payload();
        t_ifu_addr  = $urandom(); t_lsu_addr = $urandom();
        t_lsu_wen   = 1'($urandom()); t_lsu_wdata = $urandom();
        t_lsu_wmask = 8'($urandom()); t_mem_rdata = $urandom();
        t_mem_err   = ($urandom_range(0, 4) == 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit iv, lv;
        int rd, dr;
        rst = 1'b1;
        idle_inputs();
        exp_last_lsu = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;

        // IFU fetch at minimum latency.
        rand_payload();
        t_ifu_addr = 32'h8000_0000; t_mem_rdata = 32'h0010_0073; t_mem_err = 1'b0;
        run_txn(1'b1, 1'b0, 0, 1, 1'b0);

        // LSU write with memory back-pressure.
        rand_payload();
        t_lsu_addr = 32'h8000_1004; t_lsu_wen = 1'b1; t_lsu_wdata = 32'hDEAD_BEEF;
        t_lsu_wmask = 8'h0F; t_mem_err = 1'b0;
        run_txn(1'b0, 1'b1, 4, 1, 1'b0);

        // Ties alternate.
        rand_payload(); t_lsu_wen = 1'b0; run_txn(1'b1, 1'b1, 0, 1, 1'b0);
        rand_payload(); t_lsu_wen = 1'b0; run_txn(1'b1, 1'b1, 0, 1, 1'b0);

        // Memory never answers, then answers late.
        rand_payload(); t_lsu_wen = 1'b0;
        run_txn(1'b0, 1'b1, 0, NEVER, 1'b0);
        idle_stray();

        // Response on the very expiry cycle wins.
        rand_payload(); run_txn(1'b1, 1'b0, 0, TIMEOUT - 1, 1'b0);

        // Memory error on an IFU read.
        rand_payload(); t_mem_err = 1'b1; run_txn(1'b1, 1'b0, 1, 2, 1'b0);

        // Reset while waiting for memory.
        ifu_req_valid = 1'b1; ifu_addr = $urandom();
        @(posedge clk); #1;
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_last_lsu = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        @(posedge clk); #1;
        idle_stray();
        rand_payload(); t_mem_err = 1'b0; run_txn(1'b1, 1'b0, 0, 1, 1'b0);
        rand_payload(); run_txn(1'b1, 1'b1, 0, 1, 1'b0);

        for (int i = 0; i < 200; i++) begin
            rand_payload();
            iv = 1'($urandom()); lv = 1'($urandom());
            if (!iv && !lv) iv = 1'b1;
            rd = ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 3));
            dr = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(1, 4));
            run_txn(iv, lv, rd, dr, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
